// File: rtl/sobel_window_gen.sv
// -----------------------------------------------------------------------------
// sobel_window_gen
// Upstream feeder of the Sobel gradient stage. Accepts a raster-order pixel
// stream, keeps two lines of history and emits one border-masked 3x3
// neighbourhood per image position, in raster order, one per cycle.
//
// Optional build macro: WINGEN_REPLICATE_EN
//   undefined : border elements outside the image are forced to 0
//   defined   : border elements take the nearest in-image pixel
//
// Ports:
//   CLK        in   rising-edge clock
//   RSTn       in   asynchronous active-low reset
//   Start      in   frame start request (honoured in IDLE only)
//   DataIn     in   pixel data (DW bits)
//   DataValid  in   DataIn valid
//   InReady    out  pixel accepted when DataValid && InReady
//   Win        out  window, Win[DW*(3*i+j)+:DW] = P(Row-1+i, Col-1+j)
//   WinValid   out  Win/Row/Col/isPadding valid this cycle
//   Row, Col   out  window centre coordinates
//   isPadding  out  centre lies on the image border
//   Busy       out  frame in progress
//   Finish     out  one-cycle pulse when the frame is complete
// -----------------------------------------------------------------------------
module sobel_window_gen #(
   parameter int IMG_W = 256,
   parameter int IMG_H = 256,
   parameter int DW    = 8,
   parameter int CW    = 8
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              Start,
   input  logic [DW-1:0]     DataIn,
   input  logic              DataValid,
   output logic              InReady,
   output logic [9*DW-1:0]   Win,
   output logic              WinValid,
   output logic [CW-1:0]     Row,
   output logic [CW-1:0]     Col,
   output logic              isPadding,
   output logic              Busy,
   output logic              Finish
);

   localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
   localparam logic [CW-1:0] LAST_ROW = CW'(IMG_H - 1);

   typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH, S_DONE} state_t;

   state_t          r_state;
   state_t          w_state_next;

   // Line history: r_lb0 holds the pixel one line back, r_lb1 two lines back.
   logic [DW-1:0]   r_lb0 [IMG_W];
   logic [DW-1:0]   r_lb1 [IMG_W];
   logic [DW-1:0]   r_sh  [3][3];

   logic [CW-1:0]   r_in_col;
   logic [CW-1:0]   r_in_row;
   logic [CW-1:0]   r_nxt_row;
   logic [CW-1:0]   r_nxt_col;
   logic [CW-1:0]   r_row;
   logic [CW-1:0]   r_col;
   logic            r_win_valid;
   logic            r_pad;

   logic            w_shift;
   logic            w_emit;
   logic [DW-1:0]   w_pix;
   logic [AW-1:0]   w_addr;
   logic [DW-1:0]   w_lb0_rd;
   logic [DW-1:0]   w_lb1_rd;
   logic            w_last_centre;

   assign w_addr        = r_in_col[AW-1:0];
   assign w_lb0_rd      = r_lb0[w_addr];
   assign w_lb1_rd      = r_lb1[w_addr];
   assign w_pix         = (r_state == S_FLUSH) ? '0 : DataIn;
   assign w_last_centre = (r_nxt_row == LAST_ROW) && (r_nxt_col == LAST_COL);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (Start) w_state_next = S_FILL;
         // Pixel W (first pixel of line 1) completes the fill of W+1 pixels.
         S_FILL:  if (DataValid && (r_in_row == CW'(1)) && (r_in_col == '0))
                     w_state_next = S_RUN;
         S_RUN:   if (DataValid && (r_in_row == LAST_ROW) && (r_in_col == LAST_COL))
                     w_state_next = S_FLUSH;
         S_FLUSH: if (w_last_centre) w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      InReady = 1'b0;
      Finish  = 1'b0;
      w_shift = 1'b0;
      w_emit  = 1'b0;
      Busy    = (r_state != S_IDLE);
      case (r_state)
         S_FILL: begin
            InReady = 1'b1;
            w_shift = DataValid;
         end
         S_RUN: begin
            InReady = 1'b1;
            w_shift = DataValid;
            w_emit  = DataValid;
         end
         S_FLUSH: begin
            w_shift = 1'b1;
            w_emit  = 1'b1;
         end
         S_DONE:  Finish = 1'b1;
         default: ;
      endcase
   end

   // ---------------- line buffers (not reset; stale data is always masked) ----
   always_ff @(posedge CLK) begin
      if (w_shift) begin
         r_lb1[w_addr] <= w_lb0_rd;
         r_lb0[w_addr] <= w_pix;
      end
   end

   // ---------------- 3x3 shift window ----------------
   // Newest column enters at j=2: rows hold pixels k-2W, k-W, k so that the
   // centre after the shift is pixel k-W-1.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               r_sh[i][j] <= '0;
      end else if (w_shift) begin
         for (int i = 0; i < 3; i++) begin
            r_sh[i][0] <= r_sh[i][1];
            r_sh[i][1] <= r_sh[i][2];
         end
         r_sh[0][2] <= w_lb1_rd;
         r_sh[1][2] <= w_lb0_rd;
         r_sh[2][2] <= w_pix;
      end
   end

   // ---------------- coordinate counters ----------------
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_in_col    <= '0;
         r_in_row    <= '0;
         r_nxt_row   <= '0;
         r_nxt_col   <= '0;
         r_row       <= '0;
         r_col       <= '0;
         r_pad       <= 1'b0;
         r_win_valid <= 1'b0;
      end else begin
         r_win_valid <= w_emit;
         if ((r_state == S_IDLE) && Start) begin
            r_in_col  <= '0;
            r_in_row  <= '0;
            r_nxt_row <= '0;
            r_nxt_col <= '0;
         end else begin
            if (w_shift) begin
               // Column pointer keeps wrapping through FLUSH so the virtual
               // zeros land on the right line-buffer addresses.
               r_in_col <= (r_in_col == LAST_COL) ? '0 : r_in_col + 1'b1;
               if ((r_state != S_FLUSH) && (r_in_col == LAST_COL))
                  r_in_row <= r_in_row + 1'b1;
            end
            if (w_emit) begin
               r_row <= r_nxt_row;
               r_col <= r_nxt_col;
               r_pad <= (r_nxt_row == '0) || (r_nxt_row == LAST_ROW) ||
                        (r_nxt_col == '0) || (r_nxt_col == LAST_COL);
               if (r_nxt_col == LAST_COL) begin
                  r_nxt_col <= '0;
                  r_nxt_row <= r_nxt_row + 1'b1;
               end else begin
                  r_nxt_col <= r_nxt_col + 1'b1;
               end
            end
         end
      end
   end

   // ---------------- border mask ----------------
   // At row/column boundaries the shift register carries pixels from the
   // neighbouring line (or stale history); the mask removes all of them.
   for (genvar gi = 0; gi < 3; gi++) begin : g_row
      for (genvar gj = 0; gj < 3; gj++) begin : g_col
         logic w_rpad;
         logic w_cpad;
         assign w_rpad = ((gi == 0) && (r_row == '0)) || ((gi == 2) && (r_row == LAST_ROW));
         assign w_cpad = ((gj == 0) && (r_col == '0)) || ((gj == 2) && (r_col == LAST_COL));
`ifdef WINGEN_REPLICATE_EN
         // Clamp the out-of-image index onto the centre row/column.
         logic [1:0] w_ri;
         logic [1:0] w_cj;
         assign w_ri = w_rpad ? 2'd1 : 2'(gi);
         assign w_cj = w_cpad ? 2'd1 : 2'(gj);
         assign Win[DW*(3*gi+gj) +: DW] = r_sh[w_ri][w_cj];
`else
         assign Win[DW*(3*gi+gj) +: DW] = (w_rpad || w_cpad) ? '0 : r_sh[gi][gj];
`endif
      end
   end

   assign WinValid  = r_win_valid;
   assign Row       = r_row;
   assign Col       = r_col;
   assign isPadding = r_pad;

endmodule

// File: tb/tb_sobel_window_gen.sv
module tb_sobel_window_gen;
   localparam int W  = 4;
   localparam int H  = 4;
   localparam int DW = 8;
   localparam int CW = 8;
   localparam int N  = W * H;

   logic            CLK = 1'b0;
   logic            RSTn = 1'b0;
   logic            Start = 1'b0;
   logic [DW-1:0]   DataIn = '0;
   logic            DataValid = 1'b0;
   logic            InReady;
   logic [9*DW-1:0] Win;
   logic            WinValid;
   logic [CW-1:0]   Row;
   logic [CW-1:0]   Col;
   logic            isPadding;
   logic            Busy;
   logic            Finish;

   sobel_window_gen #(.IMG_W(W), .IMG_H(H), .DW(DW), .CW(CW)) dut (
      .CLK(CLK), .RSTn(RSTn), .Start(Start), .DataIn(DataIn),
      .DataValid(DataValid), .InReady(InReady), .Win(Win),
      .WinValid(WinValid), .Row(Row), .Col(Col), .isPadding(isPadding),
      .Busy(Busy), .Finish(Finish)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int frame_pix[N];

   logic [9*DW-1:0] win_q[$];
   int              row_q[$];
   int              col_q[$];
   bit              pad_q[$];
   int              wcyc_q[$];
   int              acc_q[$];
   int              fin_q[$];

   // Monitor: an accept seen here takes effect at the next rising edge, so
   // the resulting window shows up one sample later.
   always @(negedge CLK) begin
      cyc++;
      if (InReady && DataValid) acc_q.push_back(cyc);
      if (WinValid) begin
         win_q.push_back(Win);
         row_q.push_back(int'(Row));
         col_q.push_back(int'(Col));
         pad_q.push_back(isPadding);
         wcyc_q.push_back(cyc);
      end
      if (Finish) fin_q.push_back(cyc);
   end

   // Reference: neighbourhood of centre n straight from the frame array.
   function automatic logic [9*DW-1:0] exp_win(int n);
      logic [9*DW-1:0] v;
      int r, c, rr, cc;
      v = '0;
      r = n / W;
      c = n % W;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            rr = r - 1 + i;
            cc = c - 1 + j;
`ifdef WINGEN_REPLICATE_EN
            if (rr < 0) rr = 0;
            if (rr > H - 1) rr = H - 1;
            if (cc < 0) cc = 0;
            if (cc > W - 1) cc = W - 1;
            v[DW*(3*i+j) +: DW] = DW'(frame_pix[rr*W+cc]);
`else
            if (rr >= 0 && rr < H && cc >= 0 && cc < W)
               v[DW*(3*i+j) +: DW] = DW'(frame_pix[rr*W+cc]);
`endif
         end
      end
      return v;
   endfunction

   function automatic logic [9*DW-1:0] pack9(int e[9]);
      logic [9*DW-1:0] v;
      for (int k = 0; k < 9; k++) v[DW*k +: DW] = DW'(e[k]);
      return v;
   endfunction

   // Drives one frame from frame_pix; vmode 0=continuous, 1=alternating,
   // 2=random DataValid. Returns when Finish was seen (or a bound expired).
   task automatic run_frame(input int vmode, input bit start_in_run,
                            input bit valid_in_idle, output bit ok);
      int idx, guard;
      bit acc;
      win_q.delete(); row_q.delete(); col_q.delete(); pad_q.delete();
      wcyc_q.delete(); acc_q.delete(); fin_q.delete();
      if (valid_in_idle) begin
         DataValid = 1'b1;
         DataIn = 8'hAA;
         repeat (3) @(posedge CLK);
         #1;
      end
      Start = 1'b1;
      @(posedge CLK); #1;
      Start = 1'b0;
      DataValid = 1'b0;
      idx = 0;
      guard = 0;
      while (idx < N && guard < 2000) begin
         case (vmode)
            0:       DataValid = 1'b1;
            1:       DataValid = (guard % 2 == 0);
            default: DataValid = ($urandom_range(0, 2) != 0);
         endcase
         DataIn = DW'(frame_pix[idx]);
         Start  = start_in_run && (idx == 8);
         @(negedge CLK);
         acc = InReady && DataValid;
         @(posedge CLK); #1;
         if (acc) idx++;
         guard++;
      end
      DataValid = 1'b0;
      Start = 1'b0;
      DataIn = '0;
      guard = 0;
      while (fin_q.size() == 0 && guard < 200) begin
         @(posedge CLK);
         guard++;
      end
      repeat (3) @(posedge CLK);
      #1;
      ok = (idx == N) && (fin_q.size() > 0);
   endtask

   task automatic test_reset;
      RSTn = 1'b0;
      repeat (2) @(posedge CLK);
      #2;
      n_cmp++;
      if ({InReady, Busy, WinValid, isPadding, Finish} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b want 00000", {InReady, Busy, WinValid, isPadding, Finish});
      end
      n_cmp++;
      if ({Win, Row, Col} !== '0) begin
         n_bad++;
         $display("FAIL reset_data: got win=%h row=%0d col=%0d want all 0", Win, Row, Col);
      end
      RSTn = 1'b1;
      DataValid = 1'b1;
      DataIn = 8'h55;
      repeat (3) @(posedge CLK);
      #2;
      n_cmp++;
      if ({InReady, Busy} !== 2'b00) begin
         n_bad++;
         $display("FAIL idle_ignore_valid: got ready/busy=%b want 00", {InReady, Busy});
      end
      DataValid = 1'b0;
      @(posedge CLK); #1;
   endtask

   task automatic test_fixed_frame;
      bit ok;
      int e00[9], e11[9], e33[9];
      int last;
      logic [9*DW-1:0] x;
`ifdef WINGEN_REPLICATE_EN
      e00 = '{1, 1, 2, 1, 1, 2, 5, 5, 6};
      e33 = '{11, 12, 12, 15, 16, 16, 15, 16, 16};
`else
      e00 = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
      e33 = '{11, 12, 0, 15, 16, 0, 0, 0, 0};
`endif
      e11 = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
      for (int i = 0; i < N; i++) frame_pix[i] = i + 1;
      run_frame(0, 1'b0, 1'b0, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL fixed_done: frame did not complete"); end
      n_cmp++;
      if (win_q.size() != N) begin
         n_bad++;
         $display("FAIL fixed_count: got %0d windows want %0d", win_q.size(), N);
      end
      n_cmp++;
      if (fin_q.size() != 1) begin
         n_bad++;
         $display("FAIL fixed_finish_pulses: got %0d want 1", fin_q.size());
      end
      if (win_q.size() == N && acc_q.size() == N && fin_q.size() >= 1) begin
         n_cmp++;
         if (wcyc_q[0] != acc_q[W+1] + 1) begin
            n_bad++;
            $display("FAIL first_window_cycle: got %0d want %0d", wcyc_q[0], acc_q[W+1] + 1);
         end
         x = pack9(e00);
         n_cmp++;
         if (win_q[0] !== x || row_q[0] != 0 || col_q[0] != 0 || pad_q[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL centre_0_0: got %h (%0d,%0d) pad=%b want %h (0,0) pad=1",
                     win_q[0], row_q[0], col_q[0], pad_q[0], x);
         end
         x = pack9(e11);
         n_cmp++;
         if (win_q[5] !== x || row_q[5] != 1 || col_q[5] != 1 || pad_q[5] !== 1'b0) begin
            n_bad++;
            $display("FAIL centre_1_1: got %h (%0d,%0d) pad=%b want %h (1,1) pad=0",
                     win_q[5], row_q[5], col_q[5], pad_q[5], x);
         end
         x = pack9(e33);
         n_cmp++;
         if (win_q[15] !== x || row_q[15] != 3 || col_q[15] != 3 || pad_q[15] !== 1'b1) begin
            n_bad++;
            $display("FAIL centre_3_3: got %h (%0d,%0d) pad=%b want %h (3,3) pad=1",
                     win_q[15], row_q[15], col_q[15], pad_q[15], x);
         end
         last = wcyc_q[N-1];
         n_cmp++;
         if (fin_q[0] < last || fin_q[0] > last + 1) begin
            n_bad++;
            $display("FAIL finish_timing: got cycle %0d want %0d or %0d", fin_q[0], last, last + 1);
         end
      end
      n_cmp++;
      if (Busy !== 1'b0) begin n_bad++; $display("FAIL busy_after_frame: got %b want 0", Busy); end
   endtask

   // Table of frame scenarios, each compared window-by-window to the model.
   task automatic test_frames;
      int  vmode[5]  = '{0, 1, 0, 2, 1};
      bit  fixed[5]  = '{1, 1, 0, 0, 0};
      bit  sir[5]    = '{0, 0, 1, 0, 1};
      bit  vidle[5]  = '{0, 0, 1, 0, 1};
      bit  ok;
      int  want;
      for (int s = 0; s < 5; s++) begin
         for (int i = 0; i < N; i++)
            frame_pix[i] = fixed[s] ? i + 1 : int'($urandom_range(0, 255));
         run_frame(vmode[s], sir[s], vidle[s], ok);
         n_cmp++;
         if (!ok || win_q.size() != N || acc_q.size() != N || fin_q.size() != 1) begin
            n_bad++;
            $display("FAIL scen%0d_counts: done=%b windows=%0d accepts=%0d finish=%0d want 1/%0d/%0d/1",
                     s, ok, win_q.size(), acc_q.size(), fin_q.size(), N, N);
         end
         for (int n = 0; n < win_q.size() && n < N; n++) begin
            n_cmp++;
            if (win_q[n] !== exp_win(n) || row_q[n] != n / W || col_q[n] != n % W ||
                pad_q[n] !== (n / W == 0 || n / W == H - 1 || n % W == 0 || n % W == W - 1)) begin
               n_bad++;
               $display("FAIL scen%0d_win%0d: got %h (%0d,%0d) pad=%b want %h (%0d,%0d)",
                        s, n, win_q[n], row_q[n], col_q[n], pad_q[n], exp_win(n), n / W, n % W);
            end
            if (acc_q.size() == N) begin
               want = (n + W + 1 < N) ? acc_q[n+W+1] + 1 : acc_q[N-1] + 1 + (n - (N - W - 2));
               n_cmp++;
               if (wcyc_q[n] != want) begin
                  n_bad++;
                  $display("FAIL scen%0d_timing%0d: got cycle %0d want %0d", s, n, wcyc_q[n], want);
               end
            end
         end
      end
   endtask

   task automatic test_abort;
      bit ok;
      int e00[9];
      logic [9*DW-1:0] x;
`ifdef WINGEN_REPLICATE_EN
      e00 = '{101, 101, 102, 101, 101, 102, 105, 105, 106};
`else
      e00 = '{0, 0, 0, 0, 101, 102, 0, 105, 106};
`endif
      for (int i = 0; i < N; i++) frame_pix[i] = int'($urandom_range(0, 255));
      Start = 1'b1;
      @(posedge CLK); #1;
      Start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         DataValid = 1'b1;
         DataIn = DW'(frame_pix[i]);
         @(posedge CLK); #1;
      end
      n_cmp++;
      if (Busy !== 1'b1 || WinValid !== 1'b1) begin
         n_bad++;
         $display("FAIL abort_pre: got busy=%b winvalid=%b want 1/1", Busy, WinValid);
      end
      #2;
      RSTn = 1'b0;
      #1;
      n_cmp++;
      if ({InReady, Busy, WinValid, isPadding, Finish} !== 5'b0 || {Win, Row, Col} !== '0) begin
         n_bad++;
         $display("FAIL abort_reset: got ctrl=%b win=%h row=%0d col=%0d want all 0",
                  {InReady, Busy, WinValid, isPadding, Finish}, Win, Row, Col);
      end
      DataValid = 1'b0;
      repeat (2) @(posedge CLK);
      #3;
      RSTn = 1'b1;
      @(posedge CLK); #1;
      for (int i = 0; i < N; i++) frame_pix[i] = 101 + i;
      run_frame(0, 1'b0, 1'b0, ok);
      x = pack9(e00);
      n_cmp++;
      if (!ok || win_q.size() != N) begin
         n_bad++;
         $display("FAIL abort_frame_count: done=%b windows=%0d want 1/%0d", ok, win_q.size(), N);
      end
      n_cmp++;
      if (win_q.size() == 0 || win_q[0] !== x) begin
         n_bad++;
         $display("FAIL abort_centre_0_0: got %h want %h", (win_q.size() > 0) ? win_q[0] : '0, x);
      end
      for (int n = 1; n < win_q.size() && n < N; n++) begin
         n_cmp++;
         if (win_q[n] !== exp_win(n)) begin
            n_bad++;
            $display("FAIL abort_win%0d: got %h want %h", n, win_q[n], exp_win(n));
         end
      end
   endtask

   initial begin
      test_reset;
      test_fixed_frame;
      test_frames;
      test_abort;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Upstream feeder of the Sobel gradient stage.
- Accepts a raster-order 8-bit pixel stream, buffers two image lines, and emits one zero-padded 3x3 neighbourhood per pixel, centred on every image position.
- Downstream consumes one window per cycle and applies no backpressure.

Parameters:
IMG_W, 256, image width in pixels (>=3)
IMG_H, 256, image height in pixels (>=3)
DW, 8, pixel width
CW, 8, coordinate width (>= clog2(max(IMG_W,IMG_H)))

Ports:
CLK  in  1  clock, rising edge
RSTn  in  1  asynchronous active-low reset
Start  in  1  frame start request, sampled in IDLE only
DataIn  in  DW  pixel data
DataValid  in  1  DataIn valid
InReady  out  1  pixel accepted when DataValid&&InReady
Win  out  9*DW  window; Win[DW*(3*i+j)+:DW] = P(r-1+i, c-1+j), i,j in 0..2
WinValid  out  1  Win/Row/Col/isPadding valid this cycle
Row  out  CW  centre row r
Col  out  CW  centre column c
isPadding  out  1  centre on image border (any element forced)
Busy  out  1  state != IDLE
Finish  out  1  one-cycle pulse after last window

Behaviour:
- Reset (async assert, sync-safe deassert): state IDLE; all outputs 0; all counters 0. Line-buffer RAM need not be cleared; stale contents are never emitted.
- FSM:
  - IDLE: Start=1 -> FILL.
  - FILL: InReady=1. After W+1 pixels accepted (linear index k=0..W) -> RUN.
  - RUN: InReady=1. Accepting pixel k emits centre n=k-(W+1). Last pixel (k=W*H-1) accepted -> FLUSH.
  - FLUSH: InReady=0. Injects W+1 virtual zero pixels, one per cycle, each emitting one window; after the last -> DONE.
  - DONE: Finish=1 for one cycle -> IDLE.
- Start is ignored outside IDLE. DataValid is ignored in IDLE, FLUSH and DONE.
- Window for centre n is registered: WinValid=1 in the cycle after the accept (or virtual injection) of pixel n+W+1. Row/Col = n/W, n%W, tracked by counters, no divider.
- Stall cycles (DataValid=0 in RUN): WinValid=0; window state holds.
- Exactly W*H windows per frame, raster order, no gaps during FLUSH.
- Storage: two DW x IMG_W line buffers (rows r and r+1 history) plus 3x3 register array shifted per accepted or virtual pixel.
- Padding mask on the registered window:
  - r=0: top row of the window = 0.
  - r=H-1: bottom row = 0.
  - c=0: left column = 0.
  - c=W-1: right column = 0.
  - isPadding = (r==0)|(r==H-1)|(c==0)|(c==W-1).
- Column wrap: the mask removes pixels of the adjacent line that shift in at row boundaries. No arithmetic beyond counters; pixel values pass through unmodified.
- Reset mid-frame: immediate return to IDLE, outputs 0. The next Start begins a clean frame.

Optional Feature:
- Macro WINGEN_REPLICATE_EN.
- Defined: border elements take the nearest in-image pixel instead of 0 (row/column index clamped to 0..H-1 / 0..W-1). isPadding behaves identically.
- Undefined: zero padding as above.
- Timing and window count are identical in both builds.

Test Plan:
- Reset: RSTn=0 mid-cycle -> all outputs 0 immediately; InReady=0, Busy=0.
- IMG_W=IMG_H=4, Start, pixels 1..16 with continuous DataValid:
  - First WinValid in the cycle after the 6th accepted pixel; centre (0,0) Win = {0,0,0,0,1,2,0,5,6}, isPadding=1.
  - Centre (1,1) = {1,2,3,5,6,7,9,10,11}, isPadding=0.
  - Centre (3,3) = {11,12,0,15,16,0,0,0,0}.
  - 16 windows total, then a single Finish pulse.
- Same frame with DataValid alternating 1/0 -> identical 16 windows in order; no WinValid on stall cycles before FLUSH; 5 back-to-back FLUSH windows.
- Start pulsed in RUN and DataValid=1 in IDLE -> no effect; frame output unchanged; no pixels accepted in IDLE.
- RSTn pulsed after 9 pixels, then new Start and frame 101..116 -> centre (0,0) = {0,0,0,0,101,102,0,105,106}; no values from the aborted frame appear.
- WINGEN_REPLICATE_EN defined, frame 1..16 -> centre (0,0) = {1,1,2,1,1,2,5,5,6}; centre (3,3) = {11,12,12,15,16,16,15,16,16}.
